// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//   AXI3 slave memory model. It answers the CPU's AXI master port from a
//   word-organised SRAM of 2^ADDR_W 32-bit words. Independent read and write
//   FSMs each allow one outstanding transaction. Single beats and INCR/FIXED
//   bursts are supported, with byte strobes on writes and RD_LAT extra wait
//   cycles before the first read beat.
//
// Handshake rule: a transfer happens on a rising aclk edge where valid and
// ready are both 1. A source holds its payload stable while valid=1 and
// ready=0, and never retracts valid before the transfer.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   ar* / arready          read address channel (request in, accept out)
//   r*                     read data channel (rid, rdata, rresp, rlast, rvalid
//                          out; rready in)
//   aw* / awready          write address channel
//   w* / wready            write data channel (wid is ignored)
//   b*                     write response channel (bid, bresp, bvalid out;
//                          bready in)
//   dbg_rd_state_o         read FSM state (0 R_IDLE, 1 R_WAIT, 2 R_DATA)
//   dbg_wr_state_o         write FSM state (0 W_IDLE, 1 W_DATA, 2 W_RESP)
// ---------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // debug
  output logic [1:0]  dbg_rd_state_o,
  output logic [1:0]  dbg_wr_state_o
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;

  // Address of the following beat: FIXED holds, everything else increments.
  // Full 32-bit arithmetic; carries above the index bits are simply dropped
  // when the word index is sliced out.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    next_addr = (burst == 2'b00) ? addr : addr + (32'd1 << size);
  endfunction

  logic [31:0] mem_q [2**ADDR_W];

  // ---------------------------------------------------------------- read side
  r_state_e    r_state_q;
  logic [31:0] ar_addr_q;   // address of the next beat to be loaded
  logic [7:0]  ar_len_q;
  logic [2:0]  ar_size_q;
  logic [1:0]  ar_burst_q;
  logic [7:0]  r_cnt_q;
  logic [3:0]  r_wait_q;
  logic        arready_q;
  logic [3:0]  rid_q;
  logic [31:0] rdata_q;
  logic        rlast_q;
  logic        rvalid_q;

  logic [ADDR_W-1:0] ar_idx_new;
  logic [ADDR_W-1:0] ar_idx_cur;
  assign ar_idx_new = araddr[ADDR_W+1:2];
  assign ar_idx_cur = ar_addr_q[ADDR_W+1:2];

  // Memory is read in the same edge the beat is loaded, so a write to the
  // same word on that edge is not yet visible (old data returned).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q  <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      r_wait_q   <= '0;
      arready_q  <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (arready_q && arvalid) begin
            rid_q      <= arid;
            ar_len_q   <= arlen;
            ar_size_q  <= arsize;
            ar_burst_q <= arburst;
            r_cnt_q    <= '0;
            arready_q  <= 1'b0;
            if (RD_LAT == 0) begin
              rdata_q   <= mem_q[ar_idx_new];
              rvalid_q  <= 1'b1;
              rlast_q   <= (arlen == 8'd0);
              ar_addr_q <= next_addr(araddr, arsize, arburst);
              r_state_q <= R_DATA;
            end else begin
              ar_addr_q <= araddr;
              r_wait_q  <= '0;
              r_state_q <= R_WAIT;
            end
          end else begin
            // Raised on the first edge after reset release and kept high.
            arready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_wait_q == 4'(RD_LAT - 1)) begin
            rdata_q   <= mem_q[ar_idx_cur];
            rvalid_q  <= 1'b1;
            rlast_q   <= (ar_len_q == 8'd0);
            ar_addr_q <= next_addr(ar_addr_q, ar_size_q, ar_burst_q);
            r_state_q <= R_DATA;
          end else begin
            r_wait_q <= r_wait_q + 4'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              // Back-to-back beats: next one loaded on the accepting edge.
              rdata_q   <= mem_q[ar_idx_cur];
              r_cnt_q   <= r_cnt_q + 8'd1;
              rlast_q   <= ((r_cnt_q + 8'd1) == ar_len_q);
              ar_addr_q <= next_addr(ar_addr_q, ar_size_q, ar_burst_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- write side
  w_state_e    w_state_q;
  logic [31:0] aw_addr_q;   // address of the beat currently being accepted
  logic [3:0]  aw_len_q;
  logic [2:0]  aw_size_q;
  logic [1:0]  aw_burst_q;
  logic [3:0]  aw_id_q;
  logic [3:0]  w_cnt_q;
  logic        w_err_q;     // wlast seen on a beat before the final one
  logic        awready_q;
  logic        wready_q;
  logic [3:0]  bid_q;
  logic [1:0]  bresp_q;
  logic        bvalid_q;

  logic              w_fire;
  logic              w_final;
  logic              w_err_now;
  logic [ADDR_W-1:0] aw_idx_cur;

  assign w_fire     = (w_state_q == W_DATA) && wready_q && wvalid;
  assign w_final    = (w_cnt_q == aw_len_q);
  // The burst length comes from awlen; wlast is only checked for agreement.
  assign w_err_now  = w_final ? ~wlast : wlast;
  assign aw_idx_cur = aw_addr_q[ADDR_W+1:2];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q  <= W_IDLE;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_id_q    <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
      bvalid_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (awready_q && awvalid) begin
            aw_id_q    <= awid;
            aw_addr_q  <= awaddr;
            aw_len_q   <= awlen;
            aw_size_q  <= awsize;
            aw_burst_q <= awburst;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            w_state_q  <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            aw_addr_q <= next_addr(aw_addr_q, aw_size_q, aw_burst_q);
            if (w_final) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bid_q     <= aw_id_q;
              bresp_q   <= (w_err_q || w_err_now) ? 2'b10 : 2'b00;
              w_state_q <= W_RESP;
            end else begin
              w_cnt_q <= w_cnt_q + 4'd1;
              w_err_q <= w_err_q | w_err_now;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Storage has no reset: contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[aw_idx_cur][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^wid;

  assign arready        = arready_q;
  assign rid            = rid_q;
  assign rdata          = rdata_q;
  assign rresp          = 2'b00;
  assign rlast          = rlast_q;
  assign rvalid         = rvalid_q;
  assign awready        = awready_q;
  assign wready         = wready_q;
  assign bid            = bid_q;
  assign bresp          = bresp_q;
  assign bvalid         = bvalid_q;
  assign dbg_rd_state_o = r_state_q;
  assign dbg_wr_state_o = w_state_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//   Directed bench for axi_sram_slave. Two instances share the master-side
//   payload signals; 'sel' steers the valid/ready strobes and the observed
//   outputs to one of them. dut0 uses the default parameters, dut1 uses
//   ADDR_W=10 / RD_LAT=3.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

  // ------------------------------------------------------ clock / reset block
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ shared stimulus
  logic        sel;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen;
  logic [3:0]  awlen, wstrb;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;

  // per-instance outputs
  logic        arready0, rlast0, rvalid0, awready0, wready0, bvalid0;
  logic        arready1, rlast1, rvalid1, awready1, wready1, bvalid1;
  logic [3:0]  rid0, bid0, rid1, bid1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  rresp0, bresp0, rresp1, bresp1;
  logic [1:0]  rds0, wrs0, rds1, wrs1;

  // observed (selected) outputs
  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  assign arready = sel ? arready1 : arready0;
  assign rlast   = sel ? rlast1   : rlast0;
  assign rvalid  = sel ? rvalid1  : rvalid0;
  assign awready = sel ? awready1 : awready0;
  assign wready  = sel ? wready1  : wready0;
  assign bvalid  = sel ? bvalid1  : bvalid0;
  assign rid     = sel ? rid1     : rid0;
  assign bid     = sel ? bid1     : bid0;
  assign rdata   = sel ? rdata1   : rdata0;
  assign rresp   = sel ? rresp1   : rresp0;
  assign bresp   = sel ? bresp1   : bresp0;

  axi_sram_slave #(.ADDR_W(16), .RD_LAT(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid & ~sel), .arready(arready0),
    .rid(rid0), .rdata(rdata0), .rresp(rresp0), .rlast(rlast0), .rvalid(rvalid0),
    .rready(rready & ~sel),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid & ~sel), .awready(awready0),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid & ~sel),
    .wready(wready0),
    .bid(bid0), .bresp(bresp0), .bvalid(bvalid0), .bready(bready & ~sel),
    .dbg_rd_state_o(rds0), .dbg_wr_state_o(wrs0)
  );

  axi_sram_slave #(.ADDR_W(10), .RD_LAT(3)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid & sel), .arready(arready1),
    .rid(rid1), .rdata(rdata1), .rresp(rresp1), .rlast(rlast1), .rvalid(rvalid1),
    .rready(rready & sel),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid & sel), .awready(awready1),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid & sel),
    .wready(wready1),
    .bid(bid1), .bresp(bresp1), .bvalid(bvalid1), .bready(bready & sel),
    .dbg_rd_state_o(rds1), .dbg_wr_state_o(wrs1)
  );

  // ------------------------------------------------------------------ checker
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw(input logic [3:0] id, input logic [31:0] addr,
                    input logic [3:0] len, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2;
    awvalid = 1'b1;
    while (!awready && n < 20) begin tick(); n++; end
    check("aw_ready_seen", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wid = 4'd0;
    wvalid = 1'b1;
    while (!wready && n < 20) begin tick(); n++; end
    check("w_ready_seen", 32'(wready), 32'd1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic b_resp(input logic [3:0] exp_id, input logic [1:0] exp_resp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("b_valid_seen", 32'(bvalid), 32'd1);
    check("b_id", 32'(bid), 32'(exp_id));
    check("b_resp", 32'(bresp), 32'(exp_resp));
    tick();
    bready = 1'b0;
  endtask

  task automatic ar(input logic [3:0] id, input logic [31:0] addr,
                    input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2;
    arvalid = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    check("ar_ready_seen", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] exp_data, input logic exp_last,
                        input logic [3:0] exp_id);
    int n = 0;
    rready = 1'b1;
    while (!rvalid && n < 20) begin tick(); n++; end
    check("r_valid_seen", 32'(rvalid), 32'd1);
    check("r_data", rdata, exp_data);
    check("r_last", 32'(rlast), 32'(exp_last));
    check("r_id", 32'(rid), 32'(exp_id));
    check("r_resp", 32'(rresp), 32'd0);
    tick();
    rready = 1'b0;
  endtask

  // ------------------------------------------------------------ directed steps
  int beat;

  initial begin
    aresetn = 1'b0;
    sel = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;

    // reset state
    #12;
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    aresetn = 1'b1;
    tick();
    check("post_rst_arready", 32'(arready), 32'd1);
    check("post_rst_awready", 32'(awready), 32'd1);

    // single write then single read, RD_LAT=0
    aw(4'd3, 32'h10, 4'd0, 2'b01);
    w_beat(32'hDEADBEEF, 4'hF, 1'b1);
    b_resp(4'd3, 2'b00);
    ar(4'd5, 32'h10, 8'd0, 2'b01);
    check("rd_lat0_rvalid", 32'(rvalid), 32'd1);
    r_beat(32'hDEADBEEF, 1'b1, 4'd5);
    check("rd_done_rvalid", 32'(rvalid), 32'd0);

    // byte strobes; W offered before AW must be held off
    aw(4'd1, 32'h40, 4'd0, 2'b01);
    w_beat(32'hFFFFFFFF, 4'hF, 1'b1);
    b_resp(4'd1, 2'b00);
    wdata = 32'h11223344; wstrb = 4'b0101; wlast = 1'b1; wvalid = 1'b1;
    tick(); tick();
    check("w_before_aw_wready", 32'(wready), 32'd0);
    aw(4'd2, 32'h40, 4'd0, 2'b01);
    w_beat(32'h11223344, 4'b0101, 1'b1);
    b_resp(4'd2, 2'b00);
    ar(4'd6, 32'h40, 8'd0, 2'b01);
    r_beat(32'hFF22FF44, 1'b1, 4'd6);

    // INCR write burst preload, then INCR read with rready toggling
    aw(4'd4, 32'h20, 4'd3, 2'b01);
    w_beat(32'd1, 4'hF, 1'b0);
    w_beat(32'd2, 4'hF, 1'b0);
    w_beat(32'd3, 4'hF, 1'b0);
    w_beat(32'd4, 4'hF, 1'b1);
    b_resp(4'd4, 2'b00);
    ar(4'd7, 32'h20, 8'd3, 2'b01);
    beat = 0;
    for (int c = 0; c < 8; c++) begin
      check("burst_rvalid", 32'(rvalid), 32'd1);
      check("burst_rdata",  rdata, 32'(beat + 1));
      check("burst_rlast",  32'(rlast), (beat == 3) ? 32'd1 : 32'd0);
      rready = c[0];
      tick();
      if (rready) beat++;
    end
    rready = 1'b0;
    check("burst_end_rvalid",  32'(rvalid),  32'd0);
    check("burst_end_arready", 32'(arready), 32'd1);

    // early wlast -> SLVERR, both beats still written
    aw(4'd8, 32'h80, 4'd1, 2'b01);
    w_beat(32'h111, 4'hF, 1'b1);
    w_beat(32'h222, 4'hF, 1'b1);
    b_resp(4'd8, 2'b10);
    // correct wlast -> OKAY
    aw(4'd9, 32'h90, 4'd1, 2'b01);
    w_beat(32'h333, 4'hF, 1'b0);
    w_beat(32'h444, 4'hF, 1'b1);
    b_resp(4'd9, 2'b00);
    ar(4'd1, 32'h80, 8'd1, 2'b01);
    r_beat(32'h111, 1'b0, 4'd1);
    r_beat(32'h222, 1'b1, 4'd1);
    ar(4'd2, 32'h90, 8'd1, 2'b01);
    r_beat(32'h333, 1'b0, 4'd2);
    r_beat(32'h444, 1'b1, 4'd2);

    // FIXED bursts stay on one word
    aw(4'd10, 32'hA0, 4'd1, 2'b00);
    w_beat(32'hAAAA, 4'hF, 1'b0);
    w_beat(32'hBBBB, 4'hF, 1'b1);
    b_resp(4'd10, 2'b00);
    ar(4'd3, 32'hA0, 8'd1, 2'b00);
    r_beat(32'hBBBB, 1'b0, 4'd3);
    r_beat(32'hBBBB, 1'b1, 4'd3);

    // address bits above the index alias (ADDR_W=16)
    ar(4'd4, 32'h0004_0010, 8'd0, 2'b01);
    r_beat(32'hDEADBEEF, 1'b1, 4'd4);

    // ADDR_W=10 aliasing and RD_LAT=3 on dut1
    sel = 1'b1;
    tick();
    aw(4'd1, 32'h1000, 4'd0, 2'b01);
    w_beat(32'hA5A5A5A5, 4'hF, 1'b1);
    b_resp(4'd1, 2'b00);
    ar(4'd4, 32'h0, 8'd0, 2'b01);
    check("lat3_cyc1_rvalid", 32'(rvalid), 32'd0);
    tick();
    check("lat3_cyc2_rvalid", 32'(rvalid), 32'd0);
    tick();
    check("lat3_cyc3_rvalid", 32'(rvalid), 32'd0);
    tick();
    check("lat3_cyc4_rvalid", 32'(rvalid), 32'd1);
    r_beat(32'hA5A5A5A5, 1'b1, 4'd4);
    sel = 1'b0;
    tick();

    // asynchronous reset in the middle of a read burst
    ar(4'd5, 32'h20, 8'd3, 2'b01);
    check("pre_abort_rvalid", 32'(rvalid), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("abort_rvalid",  32'(rvalid),  32'd0);
    check("abort_rlast",   32'(rlast),   32'd0);
    check("abort_arready", 32'(arready), 32'd0);
    #2 aresetn = 1'b1;
    tick();
    check("abort_rel_arready", 32'(arready), 32'd1);
    check("abort_rel_rvalid",  32'(rvalid),  32'd0);
    ar(4'd6, 32'h10, 8'd0, 2'b01);
    r_beat(32'hDEADBEEF, 1'b1, 4'd6);
    ar(4'd7, 32'h2C, 8'd0, 2'b01);
    r_beat(32'd4, 1'b1, 4'd7);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
